// File: rtl/xadac_pkg.sv
// Shared defaults and types for the XADAC instruction scheduler.
// Slot records hold the destination vreg so a completion can release its busy bit.
package xadac_pkg;

  localparam int unsigned DefNoVreg = 32;
  localparam int unsigned DefSbLen  = 4;

  localparam int unsigned VregIdxW = $clog2(DefNoVreg);
  localparam int unsigned SlotIdW  = $clog2(DefSbLen);

  typedef logic [VregIdxW-1:0] vreg_idx_t;
  typedef logic [SlotIdW-1:0]  slot_id_t;

  typedef struct packed {
    logic      valid;
    logic      vd_we;
    vreg_idx_t vd;
  } slot_t;

endpackage

// File: rtl/xadac_sched_alloc.sv
// Lowest-index free-slot picker: priority encoder over the scoreboard free mask.
module xadac_sched_alloc #(
  parameter int unsigned SbLen = xadac_pkg::DefSbLen
) (
  input  logic [SbLen-1:0]         free_mask_i,
  output logic [$clog2(SbLen)-1:0] id_o,
  output logic                     any_free_o
);

  localparam int unsigned IdW = $clog2(SbLen);

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    id_o       = '0;
    any_free_o = |free_mask_i;
    // Scan downwards so the last hit written is the lowest free index.
    for (int i = SbLen - 1; i >= 0; i--) begin
      if (free_mask_i[i]) id_o = IdW'(i);
    end
  end

endmodule

// File: rtl/xadac_sched.sv
// In-order issue scheduler with a per-vreg busy scoreboard (RAW/WAR/WAW blocking).
// Optional stall counter output enabled by defining XADAC_SCHED_STATS_EN.
module xadac_sched #(
  parameter int unsigned NoVreg = xadac_pkg::DefNoVreg,
  parameter int unsigned SbLen  = xadac_pkg::DefSbLen
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [$clog2(NoVreg)-1:0] req_vs1,
  input  logic [$clog2(NoVreg)-1:0] req_vs2,
  input  logic [$clog2(NoVreg)-1:0] req_vd,
  input  logic                      req_vs1_en,
  input  logic                      req_vs2_en,
  input  logic                      req_vd_we,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [$clog2(SbLen)-1:0]  issue_id,
  input  logic                      rsp_valid,
  input  logic [$clog2(SbLen)-1:0]  rsp_id,
  output logic [$clog2(SbLen):0]    outstanding,
  output logic                      err
`ifdef XADAC_SCHED_STATS_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  import xadac_pkg::*;

  localparam int unsigned IdW  = $clog2(SbLen);
  localparam int unsigned OutW = IdW + 1;

  slot_t             slot_q [SbLen];
  slot_t             slot_d [SbLen];
  logic [NoVreg-1:0] busy_q, busy_d;
  logic [OutW-1:0]   outstanding_q, outstanding_d;
  logic              err_q, err_d;

  logic [SbLen-1:0]  free_mask;
  logic [IdW-1:0]    alloc_id;
  logic              any_free;
  logic              hazard, stall, issue_fire, rsp_hit;

  always_comb begin
    for (int i = 0; i < SbLen; i++) free_mask[i] = ~slot_q[i].valid;
  end

  xadac_sched_alloc #(.SbLen(SbLen)) u_alloc (
    .free_mask_i (free_mask),
    .id_o        (alloc_id),
    .any_free_o  (any_free)
  );

  // Hazards look only at registered busy bits, so a release is seen one cycle later.
  assign hazard = (req_vs1_en & busy_q[req_vs1])
                | (req_vs2_en & busy_q[req_vs2])
                | (req_vd_we  & busy_q[req_vd]);
  assign stall       = hazard | ~any_free;
  assign issue_valid = req_valid & ~stall;
  assign req_ready   = issue_ready & ~stall;
  assign issue_id    = alloc_id;
  assign issue_fire  = req_valid & req_ready;
  assign rsp_hit     = rsp_valid & slot_q[rsp_id].valid;

  always_comb begin
    slot_d        = slot_q;
    busy_d        = busy_q;
    err_d         = err_q;
    outstanding_d = outstanding_q + OutW'(issue_fire) - OutW'(rsp_hit);

    if (rsp_valid) begin
      if (slot_q[rsp_id].valid) begin
        slot_d[rsp_id].valid = 1'b0;
        if (slot_q[rsp_id].vd_we) busy_d[slot_q[rsp_id].vd] = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    // The allocated slot was free last cycle, so it never collides with rsp_id, and
    // WAW blocking guarantees req_vd is not the vreg being released.
    if (issue_fire) begin
      slot_d[alloc_id] = '{valid: 1'b1, vd_we: req_vd_we, vd: vreg_idx_t'(req_vd)};
      if (req_vd_we) busy_d[req_vd] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value; the slot array is reset too because its valid bits are state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SbLen; i++) slot_q[i] <= '0;
      busy_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign outstanding = outstanding_q;
  assign err         = err_q;

`ifdef XADAC_SCHED_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else if (req_valid && stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_xadac_sched.sv
// Self-checking bench for xadac_sched: directed hazard/slot sequences plus a vector table.
module tb_xadac_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_valid, req_ready;
  logic [4:0] req_vs1, req_vs2, req_vd;
  logic       req_vs1_en, req_vs2_en, req_vd_we;
  logic       issue_valid, issue_ready;
  logic [1:0] issue_id;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [2:0] outstanding;
  logic       err;
`ifdef XADAC_SCHED_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] sb_q [$];

  always #5 clk = ~clk;

  xadac_sched dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_vs1     (req_vs1),
    .req_vs2     (req_vs2),
    .req_vd      (req_vd),
    .req_vs1_en  (req_vs1_en),
    .req_vs2_en  (req_vs2_en),
    .req_vd_we   (req_vd_we),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_id    (issue_id),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .outstanding (outstanding),
    .err         (err)
`ifdef XADAC_SCHED_STATS_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic [4:0] vs1; logic e1;
    logic [4:0] vs2; logic e2;
    logic [4:0] vd;  logic we;
    logic rv; logic ir;
    logic exp_iv; logic exp_rr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0; req_vs1_en = 1'b0; req_vs2_en = 1'b0; req_vd_we = 1'b0;
    req_vs1 = '0; req_vs2 = '0; req_vd = '0;
    issue_ready = 1'b1; rsp_valid = 1'b0; rsp_id = '0;
  endtask

  task automatic drive_req(input logic [4:0] vs1, input logic e1, input logic [4:0] vs2,
                           input logic e2, input logic [4:0] vd, input logic we,
                           input logic rv, input logic ir);
    req_vs1 = vs1; req_vs1_en = e1; req_vs2 = vs2; req_vs2_en = e2;
    req_vd = vd; req_vd_we = we; req_valid = rv; issue_ready = ir;
  endtask

  // Compare issue_id against the scoreboard when a handshake is about to complete.
  task automatic expect_issue(input string nm, input logic [1:0] exp_id);
    logic [1:0] want;
    sb_q.push_back(exp_id);
    check({nm, "_ready"}, req_ready, 1);
    if (issue_valid && req_ready && sb_q.size() > 0) begin
      want = sb_q.pop_front();
      check({nm, "_id"}, issue_id, want);
    end
  endtask

  task automatic issue(input string nm, input logic [4:0] vs1, input logic e1,
                       input logic [4:0] vd, input logic we, input logic [1:0] exp_id);
    @(negedge clk);
    drive_req(vs1, e1, 5'd0, 1'b0, vd, we, 1'b1, 1'b1);
    #1 expect_issue(nm, exp_id);
    @(negedge clk);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'd21, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd21, 1'b0, 5'd20, 1'b0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{5'd0,  1'b0, 5'd20, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd0,  1'b0, 5'd0,  1'b0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'd3,  1'b1, 5'd11, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{5'd13, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{5'd0,  1'b1, 5'd0,  1'b0, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    idle();
    rstn = 1'b0;
    req_valid = 1'b1;
    #1;
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err, 0);
    check("rst_issue_valid", issue_valid, 1);
    check("rst_req_ready", req_ready, 1);
    @(negedge clk);
    idle();
    rstn = 1'b1;

    // Downstream not ready: offered but not accepted, nothing allocated.
    @(negedge clk);
    drive_req(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    check("nordy_issue_valid", issue_valid, 1);
    check("nordy_req_ready", req_ready, 0);
    @(negedge clk);
    idle();
    #1 check("nordy_outstanding", outstanding, 0);

    // RAW on v3 held until one cycle after its completion.
    issue("raw_wr", 5'd0, 1'b0, 5'd3, 1'b1, 2'd0);
    check("raw_outstanding", outstanding, 1);
    drive_req(5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b1, 1'b1);
    #1;
    check("raw_stall_ready", req_ready, 0);
    check("raw_stall_valid", issue_valid, 0);
    @(negedge clk);
    rsp_valid = 1'b1; rsp_id = 2'd0;
    #1 check("raw_same_cycle_ready", req_ready, 0);
    @(negedge clk);
    rsp_valid = 1'b0;
    #1 expect_issue("raw_release", 2'd0);
    @(negedge clk);
    idle();
    #1 check("raw_outstanding2", outstanding, 1);

    // Fill all slots, then the fifth request stalls until a slot is released.
    issue("fill1", 5'd0, 1'b0, 5'd11, 1'b1, 2'd1);
    issue("fill2", 5'd0, 1'b0, 5'd12, 1'b1, 2'd2);
    issue("fill3", 5'd0, 1'b0, 5'd13, 1'b1, 2'd3);
    check("full_outstanding", outstanding, 4);
    drive_req(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 1'b1);
    #1;
    check("full_ready", req_ready, 0);
    check("full_valid", issue_valid, 0);
    @(negedge clk);
    rsp_valid = 1'b1; rsp_id = 2'd2;
    #1 check("full_same_cycle_ready", req_ready, 0);
    @(negedge clk);
    rsp_valid = 1'b0;
    #1 expect_issue("full_refill", 2'd2);
    @(negedge clk);
    idle();
    #1 check("refill_outstanding", outstanding, 4);

    // Free slot 1, then release slot 0 while allocating: slot 0 not yet eligible.
    rsp_valid = 1'b1; rsp_id = 2'd1;
    @(negedge clk);
    idle();
    #1 check("free1_outstanding", outstanding, 3);
    @(negedge clk);
    rsp_valid = 1'b1; rsp_id = 2'd0;
    drive_req(5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 1'b1, 1'b1);
    #1 expect_issue("swap", 2'd1);
    @(negedge clk);
    idle();
    #1 check("swap_outstanding", outstanding, 3);

    // Busy now holds v21, v20, v13; slot 0 is free.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive_req(vecs[i].vs1, vecs[i].e1, vecs[i].vs2, vecs[i].e2,
                vecs[i].vd, vecs[i].we, vecs[i].rv, vecs[i].ir);
      #1;
      check($sformatf("vec%0d_issue_valid", i), issue_valid, vecs[i].exp_iv);
      check($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].exp_rr);
    end
    @(negedge clk);
    idle();
    #1 check("vec_outstanding", outstanding, 3);

    // Completion for a free slot raises a sticky error and changes nothing else.
    @(negedge clk);
    rsp_valid = 1'b1; rsp_id = 2'd0;
    #1 check("err_before", err, 0);
    @(negedge clk);
    idle();
    #1;
    check("err_set", err, 1);
    check("err_outstanding", outstanding, 3);
    @(negedge clk);
    #1 check("err_sticky", err, 1);

    // Reset mid-operation drops everything, including busy bits.
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst2_outstanding", outstanding, 0);
    check("rst2_err", err, 0);
`ifdef XADAC_SCHED_STATS_EN
    check("rst2_stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    issue("post_rst", 5'd21, 1'b1, 5'd20, 1'b1, 2'd0);
    rsp_valid = 1'b1; rsp_id = 2'd3;
    @(negedge clk);
    idle();
    #1;
    check("dropped_rsp_err", err, 1);
    check("dropped_rsp_outstanding", outstanding, 1);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xadac_sched.md
XADAC_SCHED -- requirements
Module: xadac_sched

Interface
REQ-001 SHALL have parameter NoVreg, default 32, number of vector registers.
REQ-002 SHALL have parameter SbLen, default 4, max in-flight instructions (scoreboard slots).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid / req_ready  input / output  1 / 1  upstream instruction handshake.
REQ-006 SHALL have port req_vs1, req_vs2, req_vd  input  $clog2(NoVreg) each  source and destination vreg indices.
REQ-007 SHALL have port req_vs1_en, req_vs2_en, req_vd_we  input  1 each  operand-read enables and destination-write enable.
REQ-008 SHALL have port issue_valid / issue_ready  output / input  1 / 1  downstream handshake to unit mux.
REQ-009 SHALL have port issue_id  output  $clog2(SbLen)  scoreboard slot assigned to the issued instruction.
REQ-010 SHALL have port rsp_valid  input  1  unit completion; rsp_ready is not provided (always accepted).
REQ-011 SHALL have port rsp_id  input  $clog2(SbLen)  slot being completed.
REQ-012 SHALL have port outstanding  output  $clog2(SbLen)+1  count of occupied slots.
REQ-013 SHALL have port err  output  1  sticky flag: completion for a free slot.

Function
REQ-014 SHALL compute hazard = (vs1_en & busy[vs1]) | (vs2_en & busy[vs2]) | (vd_we & busy[vd]), using registered busy only (no same-cycle bypass).
REQ-015 SHALL compute stall = hazard | all slots occupied.
REQ-016 SHALL drive issue_valid = req_valid & ~stall and req_ready = issue_ready & ~stall, combinationally.
REQ-017 SHALL drive issue_id = lowest-index free slot; value is don't-care when issue_valid = 0.
REQ-018 SHALL, on an issue handshake, mark the slot occupied, record vd and vd_we in it, and set busy[vd] if vd_we, all effective next cycle.
REQ-019 SHALL, on rsp_valid with an occupied rsp_id, free that slot and clear busy[slot.vd] if slot.vd_we, effective next cycle.
REQ-020 SHALL, on rsp_valid with a free rsp_id, leave state unchanged and set err until reset.
REQ-021 SHALL, when release and allocate occur in the same cycle, apply both; a slot freed this cycle is not eligible for allocation until the next cycle.
REQ-022 SHALL, for same-cycle release of vreg X and a request reading or writing X, stall that request one cycle (busy cleared next cycle).
REQ-023 SHALL keep outstanding = popcount(occupied); +1 on issue, -1 on valid release, net 0 when both occur.
REQ-024 SHALL hold at most one writer per vreg (guaranteed by WAW check), so busy is a single bit per vreg.
REQ-025 SHALL add zero latency on the issue path and one cycle from rsp_valid to hazard release.

Reset
REQ-026 SHALL, on rstn low, asynchronously clear all slots, busy bits, err and outstanding; req_ready and issue_valid then depend only on live inputs.
REQ-027 SHALL drop in-flight instructions on reset mid-operation; later responses for them raise err.

Configuration
REQ-028 SHALL, with XADAC_SCHED_STATS_EN defined, add output stall_cnt (32 bit) that increments each cycle req_valid & stall, saturating at all-ones, reset to 0.
REQ-029 SHALL, without XADAC_SCHED_STATS_EN, omit stall_cnt and its counter entirely.

Structure
REQ-030 SHALL take NoVreg/SbLen defaults, the vreg index type and the slot-id type from xadac_pkg.
REQ-031 SHALL implement lowest-free-slot selection in sub-module xadac_sched_alloc (leading-zero/priority encoder over the free mask).

Verification
REQ-032 Issue vd=3 we, no rsp; next req reads vs1=3 -> req_ready=0 until one cycle after rsp_id of first slot.
REQ-033 Issue 4 independent instructions (SbLen=4) -> outstanding=4, 5th stalls; rsp_id=2 -> next cycle issue_id=2.
REQ-034 Same-cycle rsp_id=0 and new request with slot 1 free -> issue_id=1, outstanding unchanged.
REQ-035 rsp_valid with rsp_id=3 while slot 3 free -> err=1 sticky, outstanding unchanged.
REQ-036 issue_ready=0 with no hazard -> issue_valid=1, req_ready=0, no slot allocated.
REQ-037 Assert rstn low with 3 outstanding -> outstanding=0, busy cleared; with STATS_EN, stall_cnt=0.
